// File: rtl/tick_countdown_if.sv
// Control and status bundle for tick_countdown: the master issues load/start/pause
// strobes and the timer (slave) reports count, tick, busy, done and state.
interface tick_countdown_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output load, load_value, start, pause,
        input  count, tick, busy, done, state
    );

    modport slave (
        input  load, load_value, start, pause,
        output count, tick, busy, done, state
    );
endinterface

// File: rtl/tick_countdown.sv
// Synchronises a slow divided square wave into clk, turns its edges into tick
// enables and uses them to drive a loadable start/pause countdown timer.
module tick_countdown #(
    parameter int WIDTH       = 8,
    parameter bit BOTH_EDGES  = 1'b1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_in,
    tick_countdown_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic             s1_reg, s2_reg, s3_reg;
    logic [1:0]       prime_reg;
    logic             edge_raw;
    logic             div_edge;
    logic             tick_reg;
    logic             done_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] reload_reg;
    state_t           state_reg;

    generate
        if (BOTH_EDGES) begin : g_both_edges
            assign edge_raw = s2_reg ^ s3_reg;
        end else begin : g_rise_edge
            assign edge_raw = s2_reg & ~s3_reg;
        end
    endgenerate

    // s3 only holds a genuine sample once three edges have passed since reset,
    // so edges are suppressed until then; a high div_in at reset gives no tick.
    assign div_edge = edge_raw & (prime_reg == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            s3_reg    <= 1'b0;
            prime_reg <= 2'd0;
            tick_reg  <= 1'b0;
        end else begin
            s1_reg   <= div_in;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            tick_reg <= div_edge;
            if (prime_reg != 2'd3) begin
                prime_reg <= prime_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.load) begin
                count_reg  <= bus.load_value;
                reload_reg <= bus.load_value;
                state_reg  <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (!bus.pause && bus.start) begin
                            if (count_reg != '0) begin
                                state_reg <= RUN;
                            end else begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        // A pause wins over an edge arriving in the same cycle.
                        if (bus.pause) begin
                            state_reg <= PAUSE;
                        end else if (div_edge) begin
                            if (count_reg <= WIDTH'(1)) begin
                                done_reg <= 1'b1;
                                if (AUTO_RELOAD && (reload_reg != '0)) begin
                                    count_reg <= reload_reg;
                                end else begin
                                    count_reg <= '0;
                                    state_reg <= DONE;
                                end
                            end else begin
                                count_reg <= count_reg - WIDTH'(1);
                            end
                        end
                    end
                    PAUSE: begin
                        if (!bus.pause && bus.start) begin
                            state_reg <= RUN;
                        end
                    end
                    DONE: begin
                        if (!bus.pause && bus.start) begin
                            if (reload_reg != '0) begin
                                count_reg <= reload_reg;
                                state_reg <= RUN;
                            end else begin
                                done_reg <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.count = count_reg;
    assign bus.tick  = tick_reg;
    assign bus.done  = done_reg;
    assign bus.state = state_reg;
    assign bus.busy  = (state_reg == RUN) || (state_reg == PAUSE);
endmodule
